// File: rtl/pad_cfg_ctrl.sv
// Pad configuration controller: shadow/active registers per pad behind a small register port,
// with a commit sequence that tri-states changed bidir pads around the active-register update.
module pad_cfg_ctrl #(
    parameter int unsigned NUM_BIDIR_PADS = 18,
    parameter int unsigned NUM_INPUT_PADS = 7,
    parameter int unsigned SETTLE_CYCLES  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic                      cfg_write,
    input  logic [5:0]                cfg_addr,
    input  logic [7:0]                cfg_wdata,
    output logic [7:0]                cfg_rdata,
    output logic                      cfg_rvalid,
    input  logic                      commit,
    output logic                      busy,
    input  logic [NUM_BIDIR_PADS-1:0] core_oe,
    output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
    output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
    output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
    output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
    output logic [NUM_INPUT_PADS-1:0] input_pu,
    output logic [NUM_INPUT_PADS-1:0] input_pd
);

    localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
    // Bidir field order: {PD, PU, IE, SL, CS, OE_EN}; only IE is set out of reset.
    localparam logic [5:0] BidirRst = 6'b001000;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StQuiesce,
        StApply,
        StSettle
    } state_e;

    state_e                          state_q, state_d;
    logic [CntW-1:0]                 cnt_q, cnt_d;
    logic [NUM_BIDIR_PADS-1:0]       qmask_q, qmask_d;
    logic [NUM_BIDIR_PADS-1:0][5:0]  bshadow_q, bshadow_d;
    logic [NUM_BIDIR_PADS-1:0][5:0]  bactive_q, bactive_d;
    logic [NUM_INPUT_PADS-1:0][1:0]  ishadow_q, ishadow_d;
    logic [NUM_INPUT_PADS-1:0][1:0]  iactive_q, iactive_d;
    logic [7:0]                      rdata_q, rdata_d;
    logic                            rvalid_q, rvalid_d;
    logic [NUM_BIDIR_PADS-1:0]       diff;
    logic                            acc_wr, acc_rd;
    logic                            unused_wdata;

    assign cfg_ready    = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign acc_wr       = cfg_valid & cfg_ready & cfg_write;
    assign acc_rd       = cfg_valid & cfg_ready & ~cfg_write;
    assign cfg_rdata    = rdata_q;
    assign cfg_rvalid   = rvalid_q;
    assign unused_wdata = ^cfg_wdata[7:6];

    // Register port: shadow writes and registered reads.
    always_comb begin
        bshadow_d = bshadow_q;
        ishadow_d = ishadow_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
            if (acc_wr && cfg_addr == 6'(i)) begin
                bshadow_d[i] = cfg_wdata[5:0];
            end
        end
        for (int i = 0; i < NUM_INPUT_PADS; i++) begin
            if (acc_wr && cfg_addr == 6'(32 + i)) begin
                ishadow_d[i] = cfg_wdata[1:0];
            end
        end
        if (acc_rd) begin
            rvalid_d = 1'b1;
            rdata_d  = 8'h00;
            for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
                if (cfg_addr == 6'(i)) begin
                    rdata_d = {2'b00, bshadow_q[i]};
                end
            end
            for (int i = 0; i < NUM_INPUT_PADS; i++) begin
                if (cfg_addr == 6'(32 + i)) begin
                    rdata_d = {6'b000000, ishadow_q[i]};
                end
            end
            if (cfg_addr == 6'd63) begin
                rdata_d = {7'b0000000, busy};
            end
        end
    end

    always_comb begin
        diff = '0;
        for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
            diff[i] = (bshadow_q[i] != bactive_q[i]);
        end
    end

    // Commit sequencer: mask changed pads, wait, swap active, wait, unmask.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qmask_d   = qmask_q;
        bactive_d = bactive_q;
        iactive_d = iactive_q;
        unique case (state_q)
            StIdle: begin
                if (commit) begin
                    state_d = StCompare;
                end
            end
            StCompare: begin
                qmask_d = diff;
                if (|diff) begin
                    cnt_d   = CntW'(SETTLE_CYCLES);
                    state_d = StQuiesce;
                end else begin
                    state_d = StApply;
                end
            end
            StQuiesce: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StApply;
                end
            end
            StApply: begin
                bactive_d = bshadow_q;
                iactive_d = ishadow_q;
                if (|qmask_q) begin
                    cnt_d   = CntW'(SETTLE_CYCLES);
                    state_d = StSettle;
                end else begin
                    state_d = StIdle;
                end
            end
            StSettle: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    qmask_d = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            qmask_q   <= '0;
            bshadow_q <= {NUM_BIDIR_PADS{BidirRst}};
            bactive_q <= {NUM_BIDIR_PADS{BidirRst}};
            ishadow_q <= '0;
            iactive_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qmask_q   <= qmask_d;
            bshadow_q <= bshadow_d;
            bactive_q <= bactive_d;
            ishadow_q <= ishadow_d;
            iactive_q <= iactive_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // PD wins over PU at the pad; the stored bits stay as written.
    always_comb begin
        bidir_oe = '0;
        bidir_cs = '0;
        bidir_sl = '0;
        bidir_ie = '0;
        bidir_pu = '0;
        bidir_pd = '0;
        input_pu = '0;
        input_pd = '0;
        for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
            bidir_oe[i] = bactive_q[i][0] & core_oe[i] & ~qmask_q[i];
            bidir_cs[i] = bactive_q[i][1];
            bidir_sl[i] = bactive_q[i][2];
            bidir_ie[i] = bactive_q[i][3];
            bidir_pu[i] = bactive_q[i][4] & ~bactive_q[i][5];
            bidir_pd[i] = bactive_q[i][5];
        end
        for (int i = 0; i < NUM_INPUT_PADS; i++) begin
            input_pu[i] = iactive_q[i][0] & ~iactive_q[i][1];
            input_pd[i] = iactive_q[i][1];
        end
    end

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Bench for pad_cfg_ctrl: timeline-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_pad_cfg_ctrl;

    localparam int NB = 18;
    localparam int NI = 7;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid, cfg_ready, cfg_write, cfg_rvalid, commit, busy;
    logic [5:0]    cfg_addr;
    logic [7:0]    cfg_wdata, cfg_rdata;
    logic [NB-1:0] core_oe, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
    logic [NI-1:0] input_pu, input_pd;

    always #5 clk = ~clk;

    pad_cfg_ctrl #(
        .NUM_BIDIR_PADS (NB),
        .NUM_INPUT_PADS (NI),
        .SETTLE_CYCLES  (S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_write  (cfg_write),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .cfg_rvalid (cfg_rvalid),
        .commit     (commit),
        .busy       (busy),
        .core_oe    (core_oe),
        .bidir_oe   (bidir_oe),
        .bidir_cs   (bidir_cs),
        .bidir_sl   (bidir_sl),
        .bidir_ie   (bidir_ie),
        .bidir_pu   (bidir_pu),
        .bidir_pd   (bidir_pd),
        .input_pu   (input_pu),
        .input_pd   (input_pd)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: k counts cycles since an accepted commit (0 = idle).
    logic [5:0]    m_bsh [NB];
    logic [5:0]    m_bact[NB];
    logic [1:0]    m_ish [NI];
    logic [1:0]    m_iact[NI];
    logic [7:0]    m_rdata;
    logic          m_rvalid;
    logic [NB-1:0] m_mask;
    bit            m_changed;
    int            k;

    function automatic logic [7:0] model_read(input logic [5:0] a);
        int ai = int'(a);
        if (ai < NB) return {2'b00, m_bsh[ai]};
        if (ai >= 32 && ai < 32 + NI) return {6'b0, m_ish[ai-32]};
        if (ai == 63) return {7'b0, k != 0};
        return 8'h00;
    endfunction

    initial begin
        k = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < NB; i++) begin
                    m_bsh[i]  = 6'h08;
                    m_bact[i] = 6'h08;
                end
                for (int i = 0; i < NI; i++) begin
                    m_ish[i]  = 2'b00;
                    m_iact[i] = 2'b00;
                end
                m_rdata = 8'h00; m_rvalid = 1'b0; m_mask = '0; k = 0;
            end else begin
                m_rvalid = 1'b0;
                if (k == 0 && cfg_valid) begin
                    if (cfg_write) begin
                        if (int'(cfg_addr) < NB) m_bsh[int'(cfg_addr)] = cfg_wdata[5:0];
                        else if (int'(cfg_addr) >= 32 && int'(cfg_addr) < 32 + NI)
                            m_ish[int'(cfg_addr)-32] = cfg_wdata[1:0];
                    end else begin
                        m_rdata  = model_read(cfg_addr);
                        m_rvalid = 1'b1;
                    end
                end
                if (k != 0) k++;
                else if (commit) k = 1;
                if (k == 2) begin
                    for (int i = 0; i < NB; i++) m_mask[i] = (m_bsh[i] != m_bact[i]);
                    m_changed = (m_mask != '0);
                end
                if (k == (m_changed ? 3 + S : 3)) begin
                    for (int i = 0; i < NB; i++) m_bact[i] = m_bsh[i];
                    for (int i = 0; i < NI; i++) m_iact[i] = m_ish[i];
                end
                if (k == (m_changed ? 3 + 2 * S : 3)) begin
                    k      = 0;
                    m_mask = '0;
                end
            end
        end
    end

    logic [NB-1:0] e_oe, e_cs, e_sl, e_ie, e_pu, e_pd;
    logic [NI-1:0] e_ipu, e_ipd;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                for (int i = 0; i < NB; i++) begin
                    e_oe[i] = m_bact[i][0] & core_oe[i] & ~m_mask[i];
                    e_cs[i] = m_bact[i][1];
                    e_sl[i] = m_bact[i][2];
                    e_ie[i] = m_bact[i][3];
                    e_pu[i] = m_bact[i][4] & ~m_bact[i][5];
                    e_pd[i] = m_bact[i][5];
                end
                for (int i = 0; i < NI; i++) begin
                    e_ipu[i] = m_iact[i][0] & ~m_iact[i][1];
                    e_ipd[i] = m_iact[i][1];
                end
                check("m_busy", 32'(busy), 32'(k != 0));
                check("m_ready", 32'(cfg_ready), 32'(k == 0));
                check("m_rvalid", 32'(cfg_rvalid), 32'(m_rvalid));
                check("m_rdata", 32'(cfg_rdata), 32'(m_rdata));
                check("m_oe", 32'(bidir_oe), 32'(e_oe));
                check("m_cs", 32'(bidir_cs), 32'(e_cs));
                check("m_sl", 32'(bidir_sl), 32'(e_sl));
                check("m_ie", 32'(bidir_ie), 32'(e_ie));
                check("m_pu", 32'(bidir_pu), 32'(e_pu));
                check("m_pd", 32'(bidir_pd), 32'(e_pd));
                check("m_ipu", 32'(input_pu), 32'(e_ipu));
                check("m_ipd", 32'(input_pd), 32'(e_ipd));
            end
        end
    end

    // Directed stimulus; every task is entered and left at a falling edge.
    task automatic do_write(input logic [5:0] a, input logic [7:0] d);
        cfg_valid = 1'b1; cfg_write = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_write = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [7:0] d);
        cfg_valid = 1'b1; cfg_write = 1'b0; cfg_addr = a;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("rd_rvalid", 32'(cfg_rvalid), 32'd1);
        d = cfg_rdata;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 50 && busy; c++) @(negedge clk);
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    // Samples cycles 1..12 after a commit into bit positions 1..12.
    task automatic trace(input int pad, output logic [12:0] vb, output logic [12:0] voe,
                         output logic [12:0] vsl);
        vb = '0; voe = '0; vsl = '0;
        for (int c = 1; c <= 12; c++) begin
            vb[c]  = busy;
            voe[c] = bidir_oe[pad];
            vsl[c] = bidir_sl[pad];
            @(negedge clk);
        end
    endtask

    logic [7:0]    d;
    logic [12:0]   vb, voe, vsl;
    logic [NB-1:0] oe_before;
    int            rc, stalls;

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_write = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        commit = 1'b0; core_oe = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_ie", 32'(bidir_ie), 32'h3FFFF);
        check("rst_oe", 32'(bidir_oe), 32'h0);
        check("rst_pd", 32'(bidir_pd), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        do_read(6'd5, d);
        check("rst_rd5", 32'(d), 32'h08);
        core_oe = '1;

        // Enable pad 3 and commit.
        do_write(6'd3, 8'h09);
        do_read(6'd3, d);
        check("rd3", 32'(d), 32'h09);
        check("oe3_pre", 32'(bidir_oe[3]), 32'd0);
        do_commit();
        trace(3, vb, voe, vsl);
        check("c1_busy", 32'(vb), 32'h07FE);
        check("c1_oe3", 32'(voe), 32'h1800);

        // Glitch mask on an already-driving pad.
        do_write(6'd4, 8'h09);
        do_commit();
        wait_idle();
        check("oe4_on", 32'(bidir_oe[4]), 32'd1);
        do_write(6'd4, 8'h0D);
        do_commit();
        trace(4, vb, voe, vsl);
        check("g_busy", 32'(vb), 32'h07FE);
        check("g_oe4", 32'(voe), 32'h1802);
        check("g_sl4", 32'(vsl), 32'h1F80);

        // No-change commit with extra commit pulses while busy.
        oe_before = bidir_oe;
        do_commit();
        vb = '0;
        for (int c = 1; c <= 6; c++) begin
            vb[c]  = busy;
            commit = (c <= 2);
            @(negedge clk);
        end
        commit = 1'b0;
        check("nc_busy", 32'(vb), 32'h0006);
        check("nc_oe", 32'(bidir_oe), 32'(oe_before));

        // PU/PD conflict and unmapped addresses.
        do_write(6'd33, 8'h03);
        do_commit();
        wait_idle();
        check("ipu1", 32'(input_pu[1]), 32'd0);
        check("ipd1", 32'(input_pd[1]), 32'd1);
        do_read(6'd33, d);
        check("rd33", 32'(d), 32'h03);
        do_write(6'd50, 8'hFF);
        do_read(6'd50, d);
        check("rd50", 32'(d), 32'h00);
        do_read(6'd63, d);
        check("rd63", 32'(d), 32'h00);

        // Read held through a commit sequence.
        do_write(6'd5, 8'h01);
        do_commit();
        cfg_valid = 1'b1; cfg_write = 1'b0; cfg_addr = 6'd5;
        rc = -1; stalls = 0;
        for (int c = 1; c <= 30; c++) begin
            if (cfg_ready) begin
                rc = c;
                @(negedge clk);
                cfg_valid = 1'b0;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        check("st_cycle", 32'(rc), 32'd11);
        check("st_stalls", 32'(stalls), 32'd10);
        check("st_rvalid", 32'(cfg_rvalid), 32'd1);
        check("st_rdata", 32'(cfg_rdata), 32'h01);
        @(negedge clk);
        check("st_rvalid_off", 32'(cfg_rvalid), 32'd0);
        check("st_rdata_hold", 32'(cfg_rdata), 32'h01);

        // Reset in the middle of QUIESCE.
        do_write(6'd6, 8'h01);
        do_commit();
        @(negedge clk);
        check("q_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("qr_busy", 32'(busy), 32'd0);
        check("qr_ready", 32'(cfg_ready), 32'd1);
        check("qr_oe", 32'(bidir_oe), 32'h0);
        check("qr_ie", 32'(bidir_ie), 32'h3FFFF);
        check("qr_sl", 32'(bidir_sl), 32'h0);
        check("qr_rdata", 32'(cfg_rdata), 32'h0);
        check("qr_ipd", 32'(input_pd), 32'h0);
        rst = 1'b0;
        do_read(6'd4, d);
        check("qr_rd4", 32'(d), 32'h08);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
